// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - mode encodings shared by the universal register and its next-state logic
package ureg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_INV  = 3'b110;
  localparam mode_t MODE_SET  = 3'b111;

endpackage

// File: rtl/ureg_next.sv
// rtl/ureg_next.sv - combinational next-state function of the universal register
module ureg_next
  import ureg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  mode_t            mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] next_q
);

  logic [WIDTH-1:0] shl_q;
  logic [WIDTH-1:0] shr_q;
  logic [WIDTH-1:0] rol_q;
  logic [WIDTH-1:0] ror_q;

  // A one-bit register has no interior slice: shifts take the serial input, rotates hold.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign shl_q = sin_l;
      assign shr_q = sin_r;
      assign rol_q = q;
      assign ror_q = q;
    end else begin : g_wide
      assign shl_q = {q[WIDTH-2:0], sin_l};
      assign shr_q = {sin_r, q[WIDTH-1:1]};
      assign rol_q = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_q = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    next_q = q;
    case (mode)
      MODE_HOLD: next_q = q;
      MODE_LOAD: next_q = d;
      MODE_SHL:  next_q = shl_q;
      MODE_SHR:  next_q = shr_q;
      MODE_ROL:  next_q = rol_q;
      MODE_ROR:  next_q = ror_q;
      MODE_INV:  next_q = ~q;
      MODE_SET:  next_q = {WIDTH{1'b1}};
      default:   next_q = q;
    endcase
  end

endmodule

// File: rtl/ureg_dff.sv
// rtl/ureg_dff.sv - WIDTH-bit universal register with true/complement outputs and change flag
module ureg_dff
  import ureg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             R_n,
  input  logic             R,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             sout_l,
  output logic             sout_r,
  output logic             changed
);

  logic [WIDTH-1:0] mode_q;
  logic [WIDTH-1:0] q_d;

  ureg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q      (Q),
    .d      (D),
    .mode   (mode),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .next_q (mode_q)
  );

  // Clear outranks enable, which outranks the mode function.
  always_comb begin
    q_d = Q;
    if (R) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = mode_q;
    end
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      Q       <= RESET_VAL;
      Qn      <= ~RESET_VAL;
      changed <= 1'b0;
    end else begin
      Q       <= q_d;
      Qn      <= ~q_d;
      changed <= (q_d != Q);
    end
  end

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];

endmodule
